// File: rtl/pulse_peak_detector_if.sv
// Event handshake bundle between the pulse detector and the event FIFO / readout.
//   EVENT_VALID  master->slave  event registers hold an unconsumed event
//   EVENT_READY  slave->master  downstream accepts when VALID && READY
//   EVENT_PEAK   master->slave  maximum sample of the pulse
//   EVENT_WIDTH  master->slave  valid samples at or above the lower level
//   EVENT_TRUNC  master->slave  pulse was force-ended by width saturation
interface pulse_peak_detector_if #(
  parameter int unsigned DATA_W  = 14,
  parameter int unsigned WIDTH_W = 8
);
  logic               EVENT_VALID;
  logic               EVENT_READY;
  logic [DATA_W-1:0]  EVENT_PEAK;
  logic [WIDTH_W-1:0] EVENT_WIDTH;
  logic               EVENT_TRUNC;

  modport master (
    output EVENT_VALID, EVENT_PEAK, EVENT_WIDTH, EVENT_TRUNC,
    input  EVENT_READY
  );

  modport slave (
    input  EVENT_VALID, EVENT_PEAK, EVENT_WIDTH, EVENT_TRUNC,
    output EVENT_READY
  );
endinterface

// File: rtl/pulse_peak_detector.sv
// Threshold/hysteresis pulse detector for the cytometer sample stream.
// Reports peak, width and truncation of each pulse on a valid/ready event port.
//   CLOCK_IN      system clock, rising edge
//   RESET         synchronous, active-high
//   SAMPLE_IN     unsigned sample, consumed when SAMPLE_VALID=1
//   SAMPLE_VALID  sample qualifier; invalid cycles leave detection state untouched
//   THRESHOLD     upper trigger level
//   HYSTERESIS    lower level = THRESHOLD-HYSTERESIS, clamped at 0
//   EVENT_IF      event handshake (master side)
//   EVENT_COUNT   events loaded into the output register, saturating
//   DROP_COUNT    events lost to backpressure, saturating
//   REJECT_COUNT  pulses shorter than MIN_WIDTH, saturating
//   BUSY          a pulse is in progress
module pulse_peak_detector #(
  parameter int unsigned DATA_W    = 14,
  parameter int unsigned WIDTH_W   = 8,
  parameter int unsigned MIN_WIDTH = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 CLOCK_IN,
  input  logic                 RESET,
  input  logic [DATA_W-1:0]    SAMPLE_IN,
  input  logic                 SAMPLE_VALID,
  input  logic [DATA_W-1:0]    THRESHOLD,
  input  logic [DATA_W-1:0]    HYSTERESIS,
  pulse_peak_detector_if.master EVENT_IF,
  output logic [CNT_W-1:0]     EVENT_COUNT,
  output logic [CNT_W-1:0]     DROP_COUNT,
  output logic [CNT_W-1:0]     REJECT_COUNT,
  output logic                 BUSY
);

  localparam int unsigned MAX_WIDTH = (2 ** WIDTH_W) - 1;

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    ARMED    = 2'd1,
    PULSE    = 2'd2
  } state_t;

  state_t               r_state;
  logic [DATA_W-1:0]    r_peak;
  logic [WIDTH_W-1:0]   r_width;
  logic                 r_ev_valid;
  logic [DATA_W-1:0]    r_ev_peak;
  logic [WIDTH_W-1:0]   r_ev_width;
  logic                 r_ev_trunc;
  logic [CNT_W-1:0]     r_evt_cnt;
  logic [CNT_W-1:0]     r_drop_cnt;
  logic [CNT_W-1:0]     r_rej_cnt;
  logic                 r_busy;

  state_t               w_state_nxt;
  logic [DATA_W-1:0]    w_peak_nxt;
  logic [WIDTH_W-1:0]   w_width_nxt;
  logic [DATA_W-1:0]    w_lower;
  logic [DATA_W-1:0]    w_peak_max;
  logic [WIDTH_W-1:0]   w_width_inc;
  logic                 w_end;
  logic                 w_end_trunc;
  logic [DATA_W-1:0]    w_end_peak;
  logic [WIDTH_W-1:0]   w_end_width;
  logic                 w_reject;
  logic                 w_offer;
  logic                 w_accept;
  logic                 w_load;
  logic                 w_drop;

  // Lower level clamps at zero rather than wrapping when HYSTERESIS exceeds THRESHOLD.
  assign w_lower     = (HYSTERESIS > THRESHOLD) ? '0 : (THRESHOLD - HYSTERESIS);
  assign w_peak_max  = (SAMPLE_IN > r_peak) ? SAMPLE_IN : r_peak;
  assign w_width_inc = r_width + WIDTH_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? (v + CNT_W'(1)) : v;
  endfunction

  // Next-state, accumulators and event load/drop decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_peak_nxt  = r_peak;
    w_width_nxt = r_width;
    w_end       = 1'b0;
    w_end_trunc = 1'b0;
    w_end_peak  = r_peak;
    w_end_width = r_width;

    if (SAMPLE_VALID) begin
      unique case (r_state)
        WAIT_LOW: begin
          if (SAMPLE_IN < w_lower) w_state_nxt = ARMED;
        end
        ARMED: begin
          if (SAMPLE_IN >= THRESHOLD) begin
            w_state_nxt = PULSE;
            w_peak_nxt  = SAMPLE_IN;
            w_width_nxt = WIDTH_W'(1);
          end
        end
        PULSE: begin
          if (SAMPLE_IN < w_lower) begin
            // Ending sample is not part of the pulse.
            w_end       = 1'b1;
            w_state_nxt = ARMED;
            w_peak_nxt  = '0;
            w_width_nxt = '0;
          end else begin
            w_end_peak  = w_peak_max;
            w_end_width = w_width_inc;
            if (w_width_inc == WIDTH_W'(MAX_WIDTH)) begin
              // Saturated: force the end and require a low sample before re-arming.
              w_end       = 1'b1;
              w_end_trunc = 1'b1;
              w_state_nxt = WAIT_LOW;
              w_peak_nxt  = '0;
              w_width_nxt = '0;
            end else begin
              w_peak_nxt  = w_peak_max;
              w_width_nxt = w_width_inc;
            end
          end
        end
        default: w_state_nxt = WAIT_LOW;
      endcase
    end

    w_reject = w_end && (w_end_width < WIDTH_W'(MIN_WIDTH));
    w_offer  = w_end && !w_reject;
    w_accept = r_ev_valid && EVENT_IF.EVENT_READY;
    // A slot being emptied this cycle may be refilled on the same edge.
    w_load   = w_offer && (!r_ev_valid || EVENT_IF.EVENT_READY);
    w_drop   = w_offer && !w_load;
  end

  // State, accumulators, event holding register and statistics.
  always_ff @(posedge CLOCK_IN) begin
    if (RESET) begin
      r_state    <= WAIT_LOW;
      r_peak     <= '0;
      r_width    <= '0;
      r_ev_valid <= 1'b0;
      r_ev_peak  <= '0;
      r_ev_width <= '0;
      r_ev_trunc <= 1'b0;
      r_evt_cnt  <= '0;
      r_drop_cnt <= '0;
      r_rej_cnt  <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_peak     <= w_peak_nxt;
      r_width    <= w_width_nxt;
      r_busy     <= (w_state_nxt == PULSE);
      if (w_load) begin
        r_ev_valid <= 1'b1;
        r_ev_peak  <= w_end_peak;
        r_ev_width <= w_end_width;
        r_ev_trunc <= w_end_trunc;
      end else if (w_accept) begin
        r_ev_valid <= 1'b0;
      end
      r_evt_cnt  <= sat_inc(r_evt_cnt, w_load);
      r_drop_cnt <= sat_inc(r_drop_cnt, w_drop);
      r_rej_cnt  <= sat_inc(r_rej_cnt, w_reject);
    end
  end

  assign EVENT_IF.EVENT_VALID = r_ev_valid;
  assign EVENT_IF.EVENT_PEAK  = r_ev_peak;
  assign EVENT_IF.EVENT_WIDTH = r_ev_width;
  assign EVENT_IF.EVENT_TRUNC = r_ev_trunc;
  assign EVENT_COUNT          = r_evt_cnt;
  assign DROP_COUNT           = r_drop_cnt;
  assign REJECT_COUNT         = r_rej_cnt;
  assign BUSY                 = r_busy;

endmodule
